des_block_packer: RTL and testbench

Upstream feeder for the pipelined DES core. Accepts a byte stream with valid/accept handshake and a last-byte marker, packs 8 bytes big-endian into one 64-bit block, and applies PKCS#5 padding at message end. Issues one-cycle block strobes that drive the core's data_i/key_i/mode_i/valid_i directly. The core has no backpressure, so the packer never stalls its output.

---
 rtl/des_block_packer.sv | 108 ++++++++++
 tb/tb_des_block_packer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_block_packer.sv
// Byte-to-block packer feeding the DES core: packs 8 bytes big-endian into a
// 64-bit block, applies PKCS#5 (or zero) padding at message end, one-cycle strobes.
module des_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mode_i,
    input  logic [0:63] key_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        accept_o,
    output logic [0:63] data_o,
    output logic [0:63] key_o,
    output logic        mode_o,
    output logic        valid_o
);

    typedef enum logic {
        FILL   = 1'b0,
        PADBLK = 1'b1
    } state_t;

    state_t      state_q;
    logic [2:0]  count_q;
    logic [0:63] acc_q;
    logic [0:63] blk_key_q;
    logic        blk_mode_q;
    logic [0:63] data_q;
    logic [0:63] key_q;
    logic        mode_q;
    logic        valid_q;

    logic [0:63] acc_d;
    logic [0:63] out_key_d;
    logic        out_mode_d;
    logic [7:0]  pad_byte;

    assign accept_o = reset_i && (state_q == FILL);
    assign data_o   = data_q;
    assign key_o    = key_q;
    assign mode_o   = mode_q;
    assign valid_o  = valid_q;

    // Block as it would look after this cycle's byte, padded if it is the last one.
    always_comb begin
        acc_d    = acc_q;
        pad_byte = PAD_EN ? {5'd0, 3'd7 - count_q} : 8'h00;
        acc_d[{count_q, 3'b000} +: 8] = byte_i;
        if (last_i) begin
            for (int i = 0; i < 8; i++) begin
                if (3'(i) > count_q) begin
                    acc_d[8*i +: 8] = pad_byte;
                end
            end
        end
        // A single-byte block has not latched key/mode yet, so take them directly.
        out_key_d  = (count_q == 3'd0) ? key_i  : blk_key_q;
        out_mode_d = (count_q == 3'd0) ? mode_i : blk_mode_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= FILL;
            count_q    <= 3'd0;
            acc_q      <= '0;
            blk_key_q  <= '0;
            blk_mode_q <= 1'b0;
            data_q     <= '0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (valid_i) begin
                        acc_q <= acc_d;
                        if (count_q == 3'd0) begin
                            blk_key_q  <= key_i;
                            blk_mode_q <= mode_i;
                        end
                        if (count_q == 3'd7 || last_i) begin
                            valid_q <= 1'b1;
                            data_q  <= acc_d;
                            key_q   <= out_key_d;
                            mode_q  <= out_mode_d;
                            count_q <= 3'd0;
                            if (PAD_EN && last_i && count_q == 3'd7) begin
                                state_q <= PADBLK;
                            end
                        end else begin
                            count_q <= count_q + 3'd1;
                        end
                    end
                end
                PADBLK: begin
                    // Aligned end: extra full pad block, key/mode held from previous block.
                    valid_q <= 1'b1;
                    data_q  <= {8{8'h08}};
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_block_packer.sv
// Directed plus random bench for des_block_packer; drives a PKCS#5 instance and a
// zero-fill instance and checks every strobe against a byte-list reference model.
module tb_des_block_packer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b0;
    logic        mode_i  = 1'b0;
    logic        last_i  = 1'b0;
    logic        valid_p = 1'b0;
    logic        valid_z = 1'b0;
    logic [0:63] key_i   = '0;
    logic [7:0]  byte_i  = '0;

    logic        acc_p, acc_z, mode_p, mode_z, vo_p, vo_z;
    logic [0:63] data_p, data_z, key_p, key_z;

    des_block_packer #(.PAD_EN(1'b1)) u_pad (
        .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .key_i(key_i),
        .byte_i(byte_i), .valid_i(valid_p), .last_i(last_i), .accept_o(acc_p),
        .data_o(data_p), .key_o(key_p), .mode_o(mode_p), .valid_o(vo_p)
    );

    des_block_packer #(.PAD_EN(1'b0)) u_zero (
        .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .key_i(key_i),
        .byte_i(byte_i), .valid_i(valid_z), .last_i(last_i), .accept_o(acc_z),
        .data_o(data_z), .key_o(key_z), .mode_o(mode_z), .valid_o(vo_z)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] key;
        logic        mode;
        int          cyc;
    } blk_t;

    blk_t        exp_p[$];
    blk_t        exp_z[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;

    // Reference model state per instance (0 = PKCS#5, 1 = zero-fill)
    logic [7:0]  mbuf[2][8];
    int          mcnt[2];
    logic [63:0] mkey[2];
    logic        mmode[2];
    int          pad_cyc[2];
    logic [63:0] last_d[2];
    logic [63:0] last_k[2];
    logic        last_m[2];
    logic [63:0] seen_d[2];
    int          n_strobe[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input int sel, input blk_t e);
        if (sel == 0) exp_p.push_back(e);
        else          exp_z.push_back(e);
    endtask

    task automatic model_xfer(input int sel, input logic [7:0] b, input logic last,
                              input logic [63:0] k, input logic m, input int t);
        logic [63:0] blk;
        logic [7:0]  padv;
        blk_t        e;
        if (mcnt[sel] == 0) begin
            mkey[sel]  = k;
            mmode[sel] = m;
        end
        mbuf[sel][mcnt[sel]] = b;
        mcnt[sel]++;
        if (mcnt[sel] == 8 || last) begin
            padv = (sel == 0) ? 8'(8 - mcnt[sel]) : 8'h00;
            blk  = '0;
            for (int i = 0; i < 8; i++)
                blk = (blk << 8) | 64'((i < mcnt[sel]) ? mbuf[sel][i] : padv);
            e.data = blk;
            e.key  = mkey[sel];
            e.mode = mmode[sel];
            e.cyc  = t + 1;
            push(sel, e);
            if (sel == 0 && mcnt[sel] == 8 && last) begin
                e.data = 64'h0808080808080808;
                e.cyc  = t + 2;
                push(sel, e);
                pad_cyc[0] = t + 1;
            end
            mcnt[sel] = 0;
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic [63:0] d,
                       input logic [63:0] k, input logic m);
        blk_t e;
        int   sz;
        if (v) begin
            n_strobe[sel]++;
            seen_d[sel] = d;
            sz = (sel == 0) ? exp_p.size() : exp_z.size();
            n_assert++;
            assert (sz > 0) else begin
                n_fail++;
                $error("FAIL strobe[%0d]: observed unexpected strobe at cycle %0d data %h, expected none", sel, cyc, d);
            end
            if (sz > 0) begin
                if (sel == 0) e = exp_p.pop_front();
                else          e = exp_z.pop_front();
                chk64($sformatf("data[%0d]", sel), d, e.data);
                chk64($sformatf("key[%0d]", sel), k, e.key);
                chk64($sformatf("mode[%0d]", sel), 64'(m), 64'(e.mode));
                chk64($sformatf("latency_cycle[%0d]", sel), 64'(cyc), 64'(e.cyc));
                last_d[sel] = e.data;
                last_k[sel] = e.key;
                last_m[sel] = e.mode;
            end
        end else begin
            chk64($sformatf("hold_data[%0d]", sel), d, last_d[sel]);
            chk64($sformatf("hold_key[%0d]", sel), k, last_k[sel]);
            chk64($sformatf("hold_mode[%0d]", sel), 64'(m), 64'(last_m[sel]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, vo_p, data_p, key_p, mode_p);
            mon(1, vo_z, data_z, key_z, mode_z);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_i = 1'b0;
        valid_p = 1'b0;
        valid_z = 1'b0;
        repeat (n) @(posedge clk);
        chk64("pending_at_reset", 64'(exp_p.size() + exp_z.size()), 64'd0);
        exp_p.delete();
        exp_z.delete();
        for (int s = 0; s < 2; s++) begin
            mcnt[s]    = 0;
            pad_cyc[s] = -1;
            last_d[s]  = '0;
            last_k[s]  = '0;
            last_m[s]  = 1'b0;
        end
        mon_en = 1'b1;
        @(negedge clk);
        chk64("accept_in_reset[0]", 64'(acc_p), 64'd0);
        chk64("accept_in_reset[1]", 64'(acc_z), 64'd0);
        reset_i = 1'b1;
    endtask

    task automatic send(input int sel, input logic [7:0] b, input logic last,
                        input logic [63:0] k, input logic m);
        int t;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            byte_i  = b;
            last_i  = last;
            key_i   = k;
            mode_i  = m;
            valid_p = (sel == 0);
            valid_z = (sel == 1);
            t = cyc;
            chk64($sformatf("accept[%0d]", sel), 64'((sel == 0) ? acc_p : acc_z),
                  (pad_cyc[sel] == t) ? 64'd0 : 64'd1);
            @(posedge clk);
            if (pad_cyc[sel] != t) begin
                model_xfer(sel, b, last, k, m, t);
                done = 1'b1;
            end
        end
        #1;
        valid_p = 1'b0;
        valid_z = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_p = 1'b0;
            valid_z = 1'b0;
            last_i  = 1'($urandom_range(0, 1));
            byte_i  = 8'($urandom_range(0, 255));
            key_i   = {$urandom, $urandom};
            mode_i  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        idle(3);
        chk64("drain[0]", 64'(exp_p.size()), 64'd0);
        chk64("drain[1]", 64'(exp_z.size()), 64'd0);
    endtask

    task automatic send_word(input int sel, input logic [63:0] w, input int nbytes,
                             input bit last_at_end, input logic [63:0] k, input logic m);
        for (int i = 0; i < nbytes; i++)
            send(sel, w[63-8*i -: 8], last_at_end && (i == nbytes - 1), k, m);
    endtask

    initial begin
        logic [63:0] k1;
        logic [63:0] k2;
        logic [63:0] rk;
        logic        rm;
        int          s0;
        int          sel;
        int          len;

        k1 = 64'h133457799BBCDFF1;
        k2 = 64'hFEDCBA9876543210;
        for (int s = 0; s < 2; s++) begin
            n_strobe[s] = 0;
            seen_d[s]   = '0;
            mcnt[s]     = 0;
            pad_cyc[s]  = -1;
        end

        do_reset(2);

        // Full block, no last
        send_word(0, 64'h0123456789ABCDEF, 8, 1'b0, k1, 1'b0);
        drain();
        chk64("t1_block", seen_d[0], 64'h0123456789ABCDEF);

        // PKCS#5 partial ends
        send_word(0, 64'hAABBCC0000000000, 3, 1'b1, k2, 1'b1);
        drain();
        chk64("t2_pad5", seen_d[0], 64'hAABBCC0505050505);
        send(0, 8'h5A, 1'b1, k1, 1'b0);
        drain();
        chk64("t2_pad7", seen_d[0], 64'h5A07070707070707);

        // Aligned end with an extra pad block; a byte offered during PADBLK waits
        s0 = n_strobe[0];
        send_word(0, 64'h0001020304050607, 8, 1'b1, k1, 1'b1);
        send(0, 8'h99, 1'b1, k2, 1'b0);
        drain();
        chk64("t3_strobes", 64'(n_strobe[0] - s0), 64'd3);
        chk64("t3_after_pad", seen_d[0], 64'h9907070707070707);

        // Zero-fill instance
        send_word(1, 64'hAABBCC0000000000, 3, 1'b1, k2, 1'b0);
        drain();
        chk64("t4_zero_fill", seen_d[1], 64'hAABBCC0000000000);
        s0 = n_strobe[1];
        send_word(1, 64'h1020304050607080, 8, 1'b1, k1, 1'b1);
        drain();
        chk64("t4_aligned_strobes", 64'(n_strobe[1] - s0), 64'd1);

        // Partial block discarded by reset
        s0 = n_strobe[0];
        send_word(0, 64'hDEADBEEFCA000000, 5, 1'b0, k2, 1'b0);
        do_reset(1);
        send_word(0, 64'h1122334455667788, 8, 1'b0, k1, 1'b0);
        drain();
        chk64("t5_strobes", 64'(n_strobe[0] - s0), 64'd1);
        chk64("t5_block", seen_d[0], 64'h1122334455667788);

        // Bubbles between bytes, key changes after byte 0
        for (int i = 0; i < 8; i++) begin
            send(0, 8'(8'h30 + i), 1'b0, (i == 0) ? k1 : {$urandom, $urandom}, 1'(i % 2));
            idle($urandom_range(1, 3));
        end
        drain();
        chk64("t6_block", seen_d[0], 64'h3031323334353637);

        // Random messages on both instances
        repeat (40) begin
            sel = $urandom_range(0, 1);
            len = $urandom_range(1, 20);
            rk  = {$urandom, $urandom};
            rm  = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 4) == 0) rk = {$urandom, $urandom};
                send(sel, 8'($urandom_range(0, 255)), j == len - 1, rk, rm);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
